// File: rtl/heap_sift_ctrl.sv
// heap_sift_ctrl: replace-top binary min-heap sequencer for an external dual-port RAM.
// Both children of a node are read together on ports a and b; INIT clears the RAM after every reset.
module heap_sift_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DEPTH-1:0]      ram_addr_a,
    output logic [DEPTH-1:0]      ram_addr_b,
    output logic                  ram_we_a,
    output logic                  ram_we_b,
    output logic [DATA_WIDTH-1:0] ram_wdata_a,
    output logic [DATA_WIDTH-1:0] ram_wdata_b,
    input  logic [DATA_WIDTH-1:0] ram_q_a,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    typedef enum logic [2:0] {INIT, IDLE, RD, WT, CMP} state_t;

    localparam logic [DEPTH-1:0] LAST = DEPTH'((1 << (DEPTH - 1)) - 1);

    state_t                state, state_n;
    logic [DEPTH-1:0]      k, i, i_n, lc, rc;
    logic [DATA_WIDTH-1:0] v, m, root_q;
    logic                  leaf, left, go;

    assign lc   = i << 1;
    assign rc   = lc | DEPTH'(1);
    assign leaf = i[DEPTH-1];
    assign left = ram_q_a <= ram_q_b;
    assign m    = left ? ram_q_a : ram_q_b;
    assign go   = in_valid & in_ready;

    // RAM controls are combinational so the CMP write can use the read data of the same cycle;
    // holding them at zero while rst is high keeps the RAM untouched during reset.
    always_comb begin
        state_n     = state;
        i_n         = i;
        in_ready    = 1'b0;
        ram_addr_a  = '0;
        ram_addr_b  = '0;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        ram_wdata_a = '0;
        ram_wdata_b = '0;
        if (!rst) begin
            case (state)
                INIT: begin
                    ram_addr_a  = k << 1;
                    ram_addr_b  = (k << 1) | DEPTH'(1);
                    ram_we_a    = 1'b1;
                    ram_we_b    = 1'b1;
                    ram_wdata_a = INIT_VAL;
                    ram_wdata_b = INIT_VAL;
                    state_n     = (k == LAST) ? IDLE : INIT;
                end
                IDLE: begin
                    in_ready = 1'b1;
                    state_n  = in_valid ? RD : IDLE;
                    i_n      = in_valid ? DEPTH'(1) : i;
                end
                RD: begin
                    ram_addr_a  = leaf ? i : lc;
                    ram_addr_b  = leaf ? '0 : rc;
                    ram_we_a    = leaf;
                    ram_wdata_a = leaf ? v : '0;
                    state_n     = leaf ? IDLE : WT;
                end
                WT: begin
                    ram_addr_a = lc;
                    ram_addr_b = rc;
                    state_n    = CMP;
                end
                CMP: begin
                    ram_addr_a  = i;
                    ram_we_a    = 1'b1;
                    ram_wdata_a = (v <= m) ? v : m;
                    state_n     = (v <= m) ? IDLE : RD;
                    i_n         = (v <= m) ? i : (left ? lc : rc);
                end
                default: state_n = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            k         <= '0;
            i         <= '0;
            v         <= '0;
            root_q    <= INIT_VAL;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            i         <= i_n;
            k         <= (state == INIT) ? k + 1'b1 : k;
            v         <= go ? in_data : v;
            out_valid <= go;
            out_data  <= go ? root_q : out_data;
            if (ram_we_a && ram_addr_a == DEPTH'(1))
                root_q <= ram_wdata_a;
            else if (ram_we_b && ram_addr_b == DEPTH'(1))
                root_q <= ram_wdata_b;
        end
    end
endmodule
